// File: rtl/list_sum_ctrl.sv
// -----------------------------------------------------------------------------
// list_sum_ctrl
//
// Purpose:
//   Control FSM for the linked-list summing datapath (data_bus). It walks a
//   list in memory starting at address 0. Each node at address p holds
//   mem[p] = next pointer and mem[p+1] = value. A next pointer of 0 ends the
//   list. The datapath holds the sum and next registers. This block only
//   sequences their load enables and muxes, and captures the final sum.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   level request, sampled only in IDLE
//   NEXT_ZERO  in   datapath status: the selected next-pointer value is 0
//   sumout     in   [N] datapath sum register
//   LD_SUM     out  sum register load enable
//   LD_NEXT    out  next register load enable
//   SUM_SEL    out  0 = load zero, 1 = load sum + mem data
//   NEXT_SEL   out  0 = load zero, 1 = load mem data
//   A_SEL      out  0 = address next, 1 = address next+1
//   busy       out  high in INIT, ADD and NEXT
//   done       out  one-cycle completion pulse (normal or guard abort)
//   result     out  [N] sum captured at completion, held until next start
//   err        out  guard abort flag, held until next accepted start
//
// Configuration:
//   LIST_GUARD_EN  when defined, a node counter aborts walks longer than
//                  MAX_NODES nodes and raises err. When undefined, no
//                  counter is built and err is constant 0.
//
// Handshake: start is a level. It is accepted only when the FSM is in IDLE.
// busy covers the whole walk, and done pulses for exactly one cycle as busy
// falls. result/err are valid from the done cycle on.
// -----------------------------------------------------------------------------
module list_sum_ctrl #(
    parameter int N         = 8,
    parameter int MAX_NODES = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         NEXT_ZERO,
    input  logic [N-1:0] sumout,
    output logic         LD_SUM,
    output logic         LD_NEXT,
    output logic         SUM_SEL,
    output logic         NEXT_SEL,
    output logic         A_SEL,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_ADD  = 3'd2,
        S_NEXT = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e       state_q, state_d;
    logic [N-1:0] result_q;
    logic         err_q;
    logic         accept;
    logic         guard_hit;

    assign accept = (state_q == S_IDLE) && start;

`ifdef LIST_GUARD_EN
    localparam int CNT_W = $clog2(MAX_NODES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_d;

    // The counter holds the number of NEXT cycles already completed. The
    // walk is cut off on the MAX_NODES-th NEXT if the list has not ended.
    assign guard_hit = (state_q == S_NEXT) && !NEXT_ZERO &&
                       (cnt_q == CNT_W'(MAX_NODES - 1));

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (accept) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else if (state_q == S_NEXT) begin
            cnt_d = cnt_q + 1'b1;
            if (guard_hit) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    // Without the guard, a cyclic list runs until rst.
    logic unused_max_nodes;
    assign unused_max_nodes = (MAX_NODES > 0);
    assign guard_hit        = 1'b0;
    assign err_q            = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_INIT;
            S_INIT: state_d = S_ADD;
            S_ADD:  state_d = S_NEXT;
            S_NEXT: state_d = (NEXT_ZERO || guard_hit) ? S_DONE : S_ADD;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs, decoded from the current state only.
    always_comb begin
        LD_SUM   = 1'b0;
        LD_NEXT  = 1'b0;
        SUM_SEL  = 1'b0;
        NEXT_SEL = 1'b0;
        A_SEL    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_INIT: begin
                // Zero both datapath registers.
                LD_SUM  = 1'b1;
                LD_NEXT = 1'b1;
                busy    = 1'b1;
            end
            S_ADD: begin
                // sum += mem[next+1]
                LD_SUM  = 1'b1;
                SUM_SEL = 1'b1;
                A_SEL   = 1'b1;
                busy    = 1'b1;
            end
            S_NEXT: begin
                // next = mem[next]
                LD_NEXT  = 1'b1;
                NEXT_SEL = 1'b1;
                busy     = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            // sumout already includes the last ADD, because ADD precedes NEXT.
            if (state_q == S_NEXT && state_d == S_DONE) begin
                result_q <= sumout;
            end
        end
    end

    assign result = result_q;
    assign err    = err_q;

endmodule

// File: tb/tb_list_sum_ctrl.sv
module tb_list_sum_ctrl;

  localparam int N = 8;
  localparam int GUARD_MAX = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic start;
  always #5 clk = ~clk;

  // dut wiring
  logic         next_zero;
  logic [N-1:0] sumout;
  logic         ld_sum, ld_next, sum_sel, next_sel, a_sel;
  logic         busy, done, err;
  logic [N-1:0] result;

  list_sum_ctrl #(.N(N), .MAX_NODES(GUARD_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .NEXT_ZERO (next_zero),
    .sumout    (sumout),
    .LD_SUM    (ld_sum),
    .LD_NEXT   (ld_next),
    .SUM_SEL   (sum_sel),
    .NEXT_SEL  (next_sel),
    .A_SEL     (a_sel),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .err       (err)
  );

  // environment: memory plus the data_bus datapath the FSM controls
  logic [N-1:0] mem [0:255];
  logic [N-1:0] dp_sum = '0;
  logic [N-1:0] dp_next = '0;
  logic [N-1:0] dp_addr, mem_data, next_in;

  assign dp_addr   = a_sel ? dp_next + 8'd1 : dp_next;
  assign mem_data  = mem[dp_addr];
  assign next_in   = next_sel ? mem_data : '0;
  assign next_zero = (next_in == '0);
  assign sumout    = dp_sum;

  always @(posedge clk) begin
    if (ld_sum)  dp_sum  <= sum_sel ? dp_sum + mem_data : '0;
    if (ld_next) dp_next <= next_in;
  end

  // scoreboard
  int n_checks = 0;
  int n_fail = 0;
  logic [N-1:0] last_result = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: plain walk over the list, optionally capped at max_nodes
  function automatic void ref_walk(input int max_nodes, output int nodes,
                                   output logic [N-1:0] sum, output bit guard);
    logic [N-1:0] p;
    logic [N-1:0] pv;
    p = '0; nodes = 0; sum = '0; guard = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      pv = p + 8'd1;
      sum = sum + mem[pv];
      nodes++;
      if (mem[p] == '0) break;
      if (max_nodes > 0 && nodes == max_nodes) begin
        guard = 1'b1;
        break;
      end
      p = mem[p];
    end
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  // One full walk from IDLE. Cycle c counts from 1 = INIT after acceptance.
  task automatic walk(input int n, input logic [N-1:0] sum_exp, input bit err_exp,
                      input bit toggle, input string tag);
    int last;
    logic [4:0] ctl_exp;
    last = 2 * n + 2;
    @(negedge clk);
    check({tag, " idle busy"}, busy, 0);
    check({tag, " idle ctl"}, {ld_sum, ld_next, sum_sel, next_sel, a_sel}, 0);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!toggle) start = 1'b0;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == 1)         ctl_exp = 5'b11000;
      else if (c == last) ctl_exp = 5'b00000;
      else if (c % 2 == 0) ctl_exp = 5'b10101;
      else                ctl_exp = 5'b01010;
      check($sformatf("%s c%0d ctl", tag, c), {ld_sum, ld_next, sum_sel, next_sel, a_sel}, ctl_exp);
      check($sformatf("%s c%0d busy", tag, c), busy, (c < last));
      check($sformatf("%s c%0d done", tag, c), done, (c == last));
      if (c < last) begin
        check($sformatf("%s c%0d result held", tag, c), result, last_result);
        check($sformatf("%s c%0d err", tag, c), err, 0);
        if (toggle) start = 1'($urandom_range(0, 1));
      end else begin
        check({tag, " result"}, result, sum_exp);
        check({tag, " err"}, err, err_exp);
        last_result = sum_exp;
      end
    end
  endtask

  task automatic run_model_walk(input string tag, input bit toggle);
    int nodes;
    logic [N-1:0] s;
    bit g;
    ref_walk(0, nodes, s, g);
    walk(nodes, s, 1'b0, toggle, tag);
  endtask

  task automatic load_two_node(input logic [N-1:0] v0, input logic [N-1:0] v1);
    clear_mem();
    mem[0] = 8'd4; mem[1] = v0;
    mem[4] = 8'd0; mem[5] = v1;
  endtask

  task automatic load_random_list();
    bit used [0:255];
    logic [N-1:0] p, q;
    int k;
    clear_mem();
    for (int i = 0; i < 256; i++) used[i] = 1'b0;
    used[0] = 1'b1;
    k = $urandom_range(1, 5);
    p = '0;
    for (int i = 0; i < k; i++) begin
      mem[p + 8'd1] = 8'($urandom);
      if (i == k - 1) begin
        mem[p] = '0;
      end else begin
        q = 8'(2 * $urandom_range(1, 126));
        while (used[q]) q = 8'(2 * $urandom_range(1, 126));
        used[q] = 1'b1;
        mem[p] = q;
        p = q;
      end
    end
  endtask

  initial begin
    int nodes;
    logic [N-1:0] s;
    bit g;
    int done_cnt;

    clear_mem();
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ctl", {ld_sum, ld_next, sum_sel, next_sel, a_sel}, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    check("reset err", err, 0);
    rst = 1'b0;

    // single node: done in cycle 4, result 9
    clear_mem();
    mem[0] = 8'd0; mem[1] = 8'd9;
    run_model_walk("single", 1'b0);

    // two nodes: done in cycle 6, result 12
    load_two_node(8'd5, 8'd7);
    run_model_walk("two", 1'b0);

    // overflow wrap: 200 + 100 = 44 mod 256
    load_two_node(8'd200, 8'd100);
    run_model_walk("wrap", 1'b0);

    // start held / toggling while busy; second walk re-accepted from IDLE
    load_two_node(8'd5, 8'd7);
    run_model_walk("held1", 1'b1);
    load_two_node(8'd200, 8'd100);
    run_model_walk("held2", 1'b1);
    start = 1'b0;

    // reset in cycle 3 of a two-node walk
    load_two_node(8'd5, 8'd7);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("rstmid c3 result held", result, last_result);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid ctl", {ld_sum, ld_next, sum_sel, next_sel, a_sel}, 0);
    check("rstmid busy", busy, 0);
    check("rstmid done", done, 0);
    check("rstmid result", result, 0);
    check("rstmid err", err, 0);
    rst = 1'b0;
    last_result = '0;
    run_model_walk("rstmid fresh", 1'b0);

    // random lists
    for (int t = 0; t < 8; t++) begin
      load_random_list();
      run_model_walk($sformatf("rand%0d", t), 1'b0);
    end

    // cyclic list: self-loop at node 2
    clear_mem();
    mem[0] = 8'd2; mem[1] = 8'd1; mem[2] = 8'd2; mem[3] = 8'd1;
`ifdef LIST_GUARD_EN
    ref_walk(GUARD_MAX, nodes, s, g);
    walk(nodes, s, g, 1'b0, "guard");
`else
    ref_walk(0, nodes, s, g);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    done_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("cyclic no done", done_cnt, 0);
    check("cyclic busy", busy, 1);
    check("cyclic err", err, 0);
    rst = 1'b1;
    @(negedge clk);
    check("cyclic rst busy", busy, 0);
    rst = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
